match_controller: RTL and testbench

- Parametrised successor to the 2-player game FSM: a match controller for NUM_PLAYERS tanks.
- Provides a menu with mode selection, tracks per-player alive state and scores, and runs rounds with a timed round-end hold.
- Declares the match winner once a player reaches the target score.
- Drives the game-state flags consumed by rgb_render, and round_reset_o consumed by map_rgb and player_rgb.

---
 rtl/match_controller_pkg.sv | 23 ++
 rtl/match_controller_if.sv | 41 ++++
 rtl/match_controller_edge_detect.sv | 27 ++
 rtl/match_controller.sv | 189 ++++++++++++++++++
 tb/tb_match_controller.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/match_controller_pkg.sv
// Shared types and helpers for the match controller.
//   game_state_e : top-level match state
//   MODE_*       : menu entry meaning
//   popcount_le1 : true when at most one bit of an (up to) 8-bit mask is set
package game_pkg;

   typedef enum logic [2:0] {
      MENU,
      PLAYING,
      ROUND_END,
      CONTINUE,
      FINAL
   } game_state_e;

   localparam int unsigned MODE_MATCH  = 0;
   localparam int unsigned MODE_SINGLE = 1;

   // Clearing the lowest set bit leaves zero iff zero or one bits were set.
   function automatic logic popcount_le1(input logic [7:0] v);
      return (v & (v - 8'd1)) == 8'd0;
   endfunction

endpackage

// File: rtl/match_controller_if.sv
// Button/hit inputs and game-state outputs of the match controller.
//   master : drives buttons and hits, observes state (board top / bench)
//   slave  : the controller itself
interface match_controller_if #(
   parameter int unsigned NUM_PLAYERS = 2,
   parameter int unsigned SCORE_BITS  = 4,
   parameter int unsigned MENU_ITEMS  = 2
);
   localparam int unsigned SelW = (MENU_ITEMS > 1) ? $clog2(MENU_ITEMS) : 1;
   localparam int unsigned PlW  = $clog2(NUM_PLAYERS);

   logic                              start_i;
   logic                              select_up_i;
   logic                              select_down_i;
   logic [NUM_PLAYERS-1:0]            hit_i;
   logic                              is_menu_o;
   logic                              is_playing_o;
   logic                              is_continue_o;
   logic                              is_final_o;
   logic                              round_reset_o;
   logic [SelW-1:0]                   menu_sel_o;
   logic [NUM_PLAYERS*SCORE_BITS-1:0] score_o;
   logic [NUM_PLAYERS-1:0]            alive_o;
   logic [PlW-1:0]                    round_winner_o;
   logic                              round_winner_valid_o;
   logic [PlW-1:0]                    match_winner_o;

   modport master (
      output start_i, select_up_i, select_down_i, hit_i,
      input  is_menu_o, is_playing_o, is_continue_o, is_final_o, round_reset_o,
      input  menu_sel_o, score_o, alive_o, round_winner_o, round_winner_valid_o,
      input  match_winner_o
   );

   modport slave (
      input  start_i, select_up_i, select_down_i, hit_i,
      output is_menu_o, is_playing_o, is_continue_o, is_final_o, round_reset_o,
      output menu_sel_o, score_o, alive_o, round_winner_o, round_winner_valid_o,
      output match_winner_o
   );
endinterface

// File: rtl/match_controller_edge_detect.sv
// Rising-edge detector for level button inputs.
//   clk_i, reset_i : clock, synchronous active-high reset
//   d_i            : level inputs
//   rise_o         : high for the cycle where d_i is 1 and the previous sample was 0
// The previous sample resets to 1 so a button held through reset does not fire.
module edge_detect #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] rise_o
);

   logic [WIDTH-1:0] prev_q, prev_d;

   always_comb begin
      prev_d = d_i;
      rise_o = d_i & ~prev_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) prev_q <= '1;
      else         prev_q <= prev_d;
   end

endmodule

// File: rtl/match_controller.sv
// Match controller for NUM_PLAYERS tanks: menu, rounds, scoring, match winner.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus (slave)    : start/up/down buttons and hit mask in; state flags, round_reset,
//                    menu selection, scores, alive mask and winners out
// All outputs come from registers; there is no combinational input-to-output path.
module match_controller
   import game_pkg::*;
#(
   parameter int unsigned NUM_PLAYERS     = 2,
   parameter int unsigned SCORE_BITS      = 4,
   parameter int unsigned ROUNDS_TO_WIN   = 3,
   parameter int unsigned ROUND_END_DELAY = 25000000,
   parameter int unsigned MENU_ITEMS      = 2
) (
   input logic               clk_i,
   input logic               reset_i,
   match_controller_if.slave bus
);

   localparam int unsigned SelW = (MENU_ITEMS > 1) ? $clog2(MENU_ITEMS) : 1;
   localparam int unsigned PlW  = $clog2(NUM_PLAYERS);
   localparam int unsigned CntW = $clog2(ROUND_END_DELAY + 1);

   localparam logic [SelW-1:0]       SelLast  = SelW'(MENU_ITEMS - 1);
   localparam logic [CntW-1:0]       CntLoad  = CntW'(ROUND_END_DELAY - 1);
   localparam logic [SCORE_BITS-1:0] ScoreMax = '1;

   logic [2:0] btn_rise;
   logic       start_rise, up_rise, down_rise;

   game_state_e                          state_q, state_d;
   logic [SelW-1:0]                      sel_q, sel_d;
   logic [SCORE_BITS-1:0]                target_q, target_d;
   logic [NUM_PLAYERS-1:0][SCORE_BITS-1:0] score_q, score_d;
   logic [NUM_PLAYERS-1:0]               alive_q, alive_d;
   logic [PlW-1:0]                       rwin_q, rwin_d;
   logic                                 rwin_valid_q, rwin_valid_d;
   logic [PlW-1:0]                       mwin_q, mwin_d;
   logic [CntW-1:0]                      cnt_q, cnt_d;

   logic [NUM_PLAYERS-1:0] alive_nxt;
   logic [PlW-1:0]         win_idx;
   logic [PlW-1:0]         best_idx;
   logic                   any_reached;

   edge_detect #(
      .WIDTH(3)
   ) u_btn_edge (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .d_i    ({bus.start_i, bus.select_up_i, bus.select_down_i}),
      .rise_o (btn_rise)
   );

   assign start_rise = btn_rise[2];
   assign up_rise    = btn_rise[1];
   assign down_rise  = btn_rise[0];

   // Round winner candidate and lowest-index target reacher.
   always_comb begin
      alive_nxt = alive_q & ~bus.hit_i;
      win_idx   = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (alive_nxt[p]) win_idx = PlW'(p);
      end
      best_idx    = '0;
      any_reached = 1'b0;
      // Scan downwards so the lowest index is the last one written.
      for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
         if (score_q[p] >= target_q) begin
            best_idx    = PlW'(p);
            any_reached = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      target_d     = target_q;
      score_d      = score_q;
      alive_d      = alive_q;
      rwin_d       = rwin_q;
      rwin_valid_d = rwin_valid_q;
      mwin_d       = mwin_q;
      cnt_d        = cnt_q;

      unique case (state_q)
         MENU: begin
            if (up_rise && !down_rise) begin
               sel_d = (sel_q == '0) ? SelLast : sel_q - 1'b1;
            end else if (down_rise && !up_rise) begin
               sel_d = (sel_q == SelLast) ? '0 : sel_q + 1'b1;
            end
            if (start_rise) begin
               target_d     = (sel_q == SelW'(MODE_SINGLE)) ? SCORE_BITS'(1)
                                                            : SCORE_BITS'(ROUNDS_TO_WIN);
               score_d      = '0;
               alive_d      = '1;
               rwin_valid_d = 1'b0;
               state_d      = PLAYING;
            end
         end

         PLAYING: begin
            alive_d = alive_nxt;
            if (popcount_le1(8'(alive_nxt))) begin
               state_d = ROUND_END;
               cnt_d   = CntLoad;
               if (alive_nxt != '0) begin
                  if (score_q[win_idx] != ScoreMax) score_d[win_idx] = score_q[win_idx] + 1'b1;
                  rwin_d       = win_idx;
                  rwin_valid_d = 1'b1;
               end else begin
                  // Simultaneous final hits: draw, last winner index is kept.
                  rwin_valid_d = 1'b0;
               end
            end
         end

         ROUND_END: begin
            if (cnt_q == '0) begin
               if (any_reached) begin
                  state_d = FINAL;
                  mwin_d  = best_idx;
               end else begin
                  state_d = CONTINUE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         CONTINUE: begin
            if (start_rise) begin
               alive_d = '1;
               state_d = PLAYING;
            end
         end

         FINAL: begin
            if (start_rise) begin
               score_d = '0;
               state_d = MENU;
            end
         end

         default: state_d = MENU;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= MENU;
         sel_q        <= '0;
         target_q     <= SCORE_BITS'(ROUNDS_TO_WIN);
         score_q      <= '0;
         alive_q      <= '1;
         rwin_q       <= '0;
         rwin_valid_q <= 1'b0;
         mwin_q       <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         target_q     <= target_d;
         score_q      <= score_d;
         alive_q      <= alive_d;
         rwin_q       <= rwin_d;
         rwin_valid_q <= rwin_valid_d;
         mwin_q       <= mwin_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.is_menu_o            = (state_q == MENU);
   assign bus.is_playing_o         = (state_q == PLAYING) || (state_q == ROUND_END);
   assign bus.is_continue_o        = (state_q == CONTINUE);
   assign bus.is_final_o           = (state_q == FINAL);
   assign bus.round_reset_o        = (state_q == MENU) || (state_q == CONTINUE) ||
                                     (state_q == FINAL);
   assign bus.menu_sel_o           = sel_q;
   assign bus.score_o              = score_q;
   assign bus.alive_o              = alive_q;
   assign bus.round_winner_o       = rwin_q;
   assign bus.round_winner_valid_o = rwin_valid_q;
   assign bus.match_winner_o       = mwin_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed scenarios with literal
// expectations, then randomized buttons/hits/resets, all checked every cycle
// against a rule-level model of the match.
module tb_match_controller;

   localparam int NP    = 3;
   localparam int SB    = 4;
   localparam int RTW   = 2;
   localparam int DELAY = 4;
   localparam int MI    = 2;

   localparam int S_MENU  = 0;
   localparam int S_PLAY  = 1;
   localparam int S_REND  = 2;
   localparam int S_CONT  = 3;
   localparam int S_FINAL = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   match_controller_if #(
      .NUM_PLAYERS(NP),
      .SCORE_BITS (SB),
      .MENU_ITEMS (MI)
   ) bus ();

   match_controller #(
      .NUM_PLAYERS    (NP),
      .SCORE_BITS     (SB),
      .ROUNDS_TO_WIN  (RTW),
      .ROUND_END_DELAY(DELAY),
      .MENU_ITEMS     (MI)
   ) dut (
      .clk_i  (clk),
      .reset_i(reset),
      .bus    (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int       m_st = S_MENU;
   int       m_sel = 0;
   int       m_target = RTW;
   int       m_score[NP];
   logic [NP-1:0] m_alive = '1;
   int       m_rw = 0;
   bit       m_rwv = 0;
   int       m_mw = 0;
   int       m_hold = 0;
   bit       m_valid = 0;
   logic [2:0] m_prev = '1;
   logic [2:0] m_cur, m_rise;
   int       m_old_sel, m_n, m_w;

   always @(posedge clk) begin
      m_cur  = {bus.start_i, bus.select_up_i, bus.select_down_i};
      m_rise = m_cur & ~m_prev;
      m_prev = m_cur;
      if (reset) begin
         m_st = S_MENU; m_sel = 0; m_target = RTW; m_alive = '1;
         m_rw = 0; m_rwv = 0; m_mw = 0; m_hold = 0; m_prev = '1; m_valid = 1;
         foreach (m_score[p]) m_score[p] = 0;
      end else begin
         case (m_st)
            S_MENU: begin
               m_old_sel = m_sel;
               if (m_rise[1] && !m_rise[0]) m_sel = (m_sel + MI - 1) % MI;
               else if (m_rise[0] && !m_rise[1]) m_sel = (m_sel + 1) % MI;
               if (m_rise[2]) begin
                  m_target = (m_old_sel == 1) ? 1 : RTW;
                  foreach (m_score[p]) m_score[p] = 0;
                  m_alive = '1;
                  m_rwv = 0;
                  m_st = S_PLAY;
               end
            end
            S_PLAY: begin
               m_alive = m_alive & ~bus.hit_i;
               m_n = $countones(m_alive);
               if (m_n <= 1) begin
                  m_st = S_REND;
                  m_hold = DELAY;
                  if (m_n == 1) begin
                     m_w = $clog2(m_alive);
                     if (m_score[m_w] < (1 << SB) - 1) m_score[m_w]++;
                     m_rw = m_w;
                     m_rwv = 1;
                  end else begin
                     m_rwv = 0;
                  end
               end
            end
            S_REND: begin
               m_hold--;
               if (m_hold == 0) begin
                  m_w = -1;
                  for (int p = 0; p < NP; p++)
                     if (m_w < 0 && m_score[p] >= m_target) m_w = p;
                  if (m_w >= 0) begin
                     m_st = S_FINAL;
                     m_mw = m_w;
                  end else begin
                     m_st = S_CONT;
                  end
               end
            end
            S_CONT: begin
               if (m_rise[2]) begin
                  m_alive = '1;
                  m_st = S_PLAY;
               end
            end
            default: begin
               if (m_rise[2]) begin
                  m_st = S_MENU;
                  foreach (m_score[p]) m_score[p] = 0;
               end
            end
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   always begin
      @(posedge clk);
      #2;
      if (m_valid) begin
         check("is_menu", 32'(bus.is_menu_o), 32'(m_st == S_MENU));
         check("is_playing", 32'(bus.is_playing_o), 32'(m_st == S_PLAY || m_st == S_REND));
         check("is_continue", 32'(bus.is_continue_o), 32'(m_st == S_CONT));
         check("is_final", 32'(bus.is_final_o), 32'(m_st == S_FINAL));
         check("round_reset", 32'(bus.round_reset_o),
               32'(m_st == S_MENU || m_st == S_CONT || m_st == S_FINAL));
         check("menu_sel", 32'(bus.menu_sel_o), 32'(m_sel));
         for (int p = 0; p < NP; p++)
            check($sformatf("score%0d", p), 32'(bus.score_o[p*SB +: SB]), 32'(m_score[p]));
         check("alive", 32'(bus.alive_o), 32'(m_alive));
         check("round_winner", 32'(bus.round_winner_o), 32'(m_rw));
         check("round_winner_valid", 32'(bus.round_winner_valid_o), 32'(m_rwv));
         if (m_st == S_FINAL) check("match_winner", 32'(bus.match_winner_o), 32'(m_mw));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic s, input logic u, input logic d, input logic [NP-1:0] h);
      bus.start_i = s;
      bus.select_up_i = u;
      bus.select_down_i = d;
      bus.hit_i = h;
      @(negedge clk);
   endtask

   // Idle-steps until the chosen flag (0 menu, 1 playing, 2 continue, 3 final) is set.
   task automatic wait_flag(input int idx, input int limit, output int n);
      logic [3:0] f;
      n = 0;
      f = {bus.is_final_o, bus.is_continue_o, bus.is_playing_o, bus.is_menu_o};
      while (f[idx] !== 1'b1 && n < limit) begin
         step(0, 0, 0, '0);
         n++;
         f = {bus.is_final_o, bus.is_continue_o, bus.is_playing_o, bus.is_menu_o};
      end
      check($sformatf("wait_flag%0d", idx), 32'(f[idx]), 32'd1);
   endtask

   initial begin
      int n;
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.start_i = 1'b1;
      bus.select_up_i = 1'b0;
      bus.select_down_i = 1'b0;
      bus.hit_i = '0;
      @(negedge clk);
      step(1, 0, 0, '0);
      step(1, 0, 0, '0);
      reset = 1'b0;
      step(1, 0, 0, '0);
      step(1, 0, 0, '0);
      check("lit_menu_after_reset", 32'(bus.is_menu_o), 32'd1);
      check("lit_sel_after_reset", 32'(bus.menu_sel_o), 32'd0);
      check("lit_rr_after_reset", 32'(bus.round_reset_o), 32'd1);
      step(0, 0, 0, '0);

      step(0, 0, 1, '0); check("lit_sel_down1", 32'(bus.menu_sel_o), 32'd1);
      step(0, 0, 0, '0);
      step(0, 0, 1, '0); check("lit_sel_down2", 32'(bus.menu_sel_o), 32'd0);
      step(0, 0, 0, '0);
      step(0, 0, 1, '0); check("lit_sel_down3", 32'(bus.menu_sel_o), 32'd1);
      step(0, 0, 0, '0);
      step(0, 1, 1, '0); check("lit_sel_updown", 32'(bus.menu_sel_o), 32'd1);
      step(0, 0, 0, '0);
      step(0, 1, 0, '0); check("lit_sel_up", 32'(bus.menu_sel_o), 32'd0);
      step(0, 0, 0, '0);

      // Round 1: player 1 wins.
      step(1, 0, 0, '0);
      check("lit_playing", 32'(bus.is_playing_o), 32'd1);
      check("lit_rr_playing", 32'(bus.round_reset_o), 32'd0);
      step(0, 0, 0, '0);
      step(0, 0, 0, 3'b001); check("lit_alive_110", 32'(bus.alive_o), 32'b110);
      step(0, 0, 0, 3'b100);
      check("lit_score_r1", 32'(bus.score_o), 32'h010);
      check("lit_rw_r1", 32'(bus.round_winner_o), 32'd1);
      check("lit_rwv_r1", 32'(bus.round_winner_valid_o), 32'd1);
      wait_flag(2, 20, n);
      check("lit_round_end_cycles", 32'(n), 32'd4);

      // Round 2: draw.
      step(1, 0, 0, '0); check("lit_alive_111", 32'(bus.alive_o), 32'b111);
      step(0, 0, 0, '0);
      step(0, 0, 0, 3'b100);
      step(0, 0, 0, 3'b011);
      check("lit_draw_valid", 32'(bus.round_winner_valid_o), 32'd0);
      check("lit_draw_rw_kept", 32'(bus.round_winner_o), 32'd1);
      check("lit_draw_score", 32'(bus.score_o), 32'h010);
      wait_flag(2, 20, n);

      // Rounds 3-4: player 2 wins twice and takes the match.
      step(1, 0, 0, '0); step(0, 0, 0, '0);
      step(0, 0, 0, 3'b011);
      check("lit_score_r3", 32'(bus.score_o), 32'h110);
      wait_flag(2, 20, n);
      step(1, 0, 0, '0); step(0, 0, 0, '0);
      step(0, 0, 0, 3'b011);
      wait_flag(3, 20, n);
      check("lit_match_winner2", 32'(bus.match_winner_o), 32'd2);
      check("lit_score_final", 32'(bus.score_o), 32'h210);
      step(1, 0, 0, '0);
      check("lit_back_menu", 32'(bus.is_menu_o), 32'd1);
      check("lit_score_cleared", 32'(bus.score_o), 32'h000);
      step(0, 0, 0, '0);

      // Single-round mode.
      step(0, 0, 1, '0); step(0, 0, 0, '0);
      step(1, 0, 0, '0); step(0, 0, 0, '0);
      step(0, 0, 0, 3'b110);
      wait_flag(3, 20, n);
      check("lit_single_winner0", 32'(bus.match_winner_o), 32'd0);
      check("lit_single_cycles", 32'(n), 32'd4);
      step(1, 0, 0, '0);
      check("lit_sel_kept", 32'(bus.menu_sel_o), 32'd1);
      step(0, 0, 0, '0);

      // Reset during ROUND_END.
      step(1, 0, 0, '0); step(0, 0, 0, '0);
      step(0, 0, 0, 3'b011);
      step(0, 0, 0, '0);
      reset = 1'b1;
      step(0, 0, 0, '0);
      check("lit_rst_menu", 32'(bus.is_menu_o), 32'd1);
      check("lit_rst_score", 32'(bus.score_o), 32'h000);
      check("lit_rst_alive", 32'(bus.alive_o), 32'b111);
      check("lit_rst_rwv", 32'(bus.round_winner_valid_o), 32'd0);
      check("lit_rst_sel", 32'(bus.menu_sel_o), 32'd0);
      reset = 1'b0;
      step(0, 0, 0, '0);

      // Randomized phase.
      for (int i = 0; i < 5000; i++) begin
         logic [NP-1:0] h;
         for (int p = 0; p < NP; p++) h[p] = ($urandom_range(0, 11) == 0);
         reset = ($urandom_range(0, 399) == 0);
         step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0, h);
      end
      reset = 1'b0;
      step(0, 0, 0, '0);
      step(0, 0, 0, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
